// File: rtl/cipher_sched_pkg.sv
// Shared types for the cipher-bus scheduler: FSM states, requester tags and sizing helpers.
// Default sizes live here so the top and any wrappers agree on them.
package cipher_sched_pkg;

  localparam int DEF_NREQ      = 2;
  localparam int DEF_TAG_DEPTH = 4;
  localparam int DEF_DATA_W    = 128;

  typedef logic         ulogic1;
  typedef logic [127:0] ulogic128;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARB      = 2'd1,
    ISSUE    = 2'd2,
    DRAIN    = 2'd3
  } sched_state_t;

  typedef logic [$clog2(DEF_NREQ)-1:0] tag_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int tag_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester tags; pop data is combinational from the head, updates take 1 cycle.
// Pushes while full and pops while empty are dropped; the caller gates both.
module tag_fifo
  import cipher_sched_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = DEF_TAG_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             resetL,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  ulogic1           do_push;
  ulogic1           do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_bus_arbiter.sv
// Round-robin sharing of one AES core among NREQ requesters; accept edge -> start pulse next cycle, result -> response 1 cycle later.
// Grants only in ARB with core ready and a free tag slot; responses cannot be backpressured.
module cipher_bus_arbiter
  import cipher_sched_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                           clk,
  input  logic                           resetL,
  input  logic                           en,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0]                req_ende,
  input  logic [NREQ*DATA_W-1:0]         req_data,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           i_enable,
  output logic                           i_ende,
  output logic [DATA_W-1:0]              i_data,
  output logic                           i_data_valid,
  input  logic                           o_ready,
  input  logic                           o_data_valid,
  input  logic [DATA_W-1:0]              o_data,
  output logic                           busy,
  output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
  output logic                           err_orphan
);

  localparam int TAG_W = tag_w(NREQ);
  localparam int CNT_W = cnt_w(TAG_DEPTH);

  sched_state_t     state;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] cand;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] pop_tag;
  ulogic1           grant_any;
  ulogic1           grant;
  ulogic1           pop;
  ulogic1           fifo_full;
  ulogic1           fifo_empty;

  // First valid requester strictly after the last winner, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = TAG_W'((int'(rr_ptr) + i) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant        = (state == ARB) && en && o_ready && !fifo_full && grant_any;
  assign req_ready    = grant ? (NREQ'(1) << grant_idx) : '0;
  assign pop          = o_data_valid && !fifo_empty;
  assign i_enable     = (state != DISABLED);
  assign i_data_valid = (state == ISSUE);
  assign busy         = (state != DISABLED) || (inflight != '0);

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state  <= DISABLED;
      rr_ptr <= TAG_W'(NREQ - 1);
      i_data <= '0;
      i_ende <= 1'b0;
    end else begin
      case (state)
        DISABLED: if (en) state <= ARB;
        ARB: begin
          if (!en) begin
            state <= DRAIN;
          end else if (grant) begin
            i_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            i_ende <= req_ende[grant_idx];
            rr_ptr <= grant_idx;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= en ? ARB : DRAIN;
        DRAIN: begin
          if (en) state <= ARB;
          else if (inflight == '0) state <= DISABLED;
        end
        default: state <= DISABLED;
      endcase
    end
  end

  // A result with no outstanding tag has no owner: flag it and drop it.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid <= NREQ'(1) << pop_tag;
        rsp_data  <= o_data;
      end else if (o_data_valid) begin
        err_orphan <= 1'b1;
      end
    end
  end

  tag_fifo #(
    .W     (TAG_W),
    .DEPTH (TAG_DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .resetL   (resetL),
    .push     (grant),
    .push_dat (grant_idx),
    .pop      (pop),
    .pop_dat  (pop_tag),
    .count    (inflight),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_cipher_bus_arbiter.sv
// Directed bench for cipher_bus_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_cipher_bus_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 128;

  localparam int S_OFF = 0;
  localparam int S_ARB = 1;
  localparam int S_ISS = 2;
  localparam int S_DRN = 3;

  logic              clk = 1'b0;
  logic              resetL = 1'b0;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ende = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              i_enable;
  logic              i_ende;
  logic [DW-1:0]     i_data;
  logic              i_data_valid;
  logic              o_ready = 1'b0;
  logic              o_data_valid = 1'b0;
  logic [DW-1:0]     o_data = '0;
  logic              busy;
  logic [2:0]        inflight;
  logic              err_orphan;

  int n_checks = 0;
  int n_errors = 0;

  cipher_bus_arbiter #(.NREQ(NREQ), .TAG_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .resetL(resetL), .en(en),
    .req_valid(req_valid), .req_ende(req_ende), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .i_enable(i_enable), .i_ende(i_ende), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_ready(o_ready), .o_data_valid(o_data_valid), .o_data(o_data),
    .busy(busy), .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int            m_st = S_OFF;
  int            m_ptr = NREQ - 1;
  int            m_q[$];
  logic [DW-1:0] m_idata = '0;
  logic          m_iende = 1'b0;
  logic [NREQ-1:0] m_rsp_valid = '0;
  logic [DW-1:0] m_rsp_data = '0;
  logic          m_orphan = 1'b0;
  int            mn, mw, mk;
  bit            mg;

  function automatic int m_winner();
    for (int i = 1; i <= NREQ; i++) begin
      int c = (m_ptr + i) % NREQ;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit m_grant();
    return (m_st == S_ARB) && en && o_ready && (m_q.size() < DEPTH) && (m_winner() >= 0);
  endfunction

  always @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      m_st = S_OFF; m_ptr = NREQ - 1; m_q.delete();
      m_idata = '0; m_iende = 1'b0; m_rsp_valid = '0; m_rsp_data = '0; m_orphan = 1'b0;
    end else begin
      mn = m_q.size();
      mg = m_grant();
      mw = m_winner();
      m_rsp_valid = '0;
      if (o_data_valid) begin
        if (mn > 0) begin
          mk = m_q.pop_front();
          m_rsp_valid = NREQ'(1) << mk;
          m_rsp_data = o_data;
        end else m_orphan = 1'b1;
      end
      if (mg) begin
        m_q.push_back(mw);
        m_idata = req_data[mw*DW +: DW];
        m_iende = req_ende[mw];
        m_ptr = mw;
      end
      case (m_st)
        S_OFF: if (en) m_st = S_ARB;
        S_ARB: if (!en) m_st = S_DRN; else if (mg) m_st = S_ISS;
        S_ISS: m_st = en ? S_ARB : S_DRN;
        default: if (en) m_st = S_ARB; else if (mn == 0) m_st = S_OFF;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rr;
    exp_rr = m_grant() ? (NREQ'(1) << m_winner()) : '0;
    chk("m_req_ready", req_ready, exp_rr);
    chk("m_i_enable", i_enable, m_st != S_OFF);
    chk("m_i_data_valid", i_data_valid, m_st == S_ISS);
    chk("m_i_data", i_data, m_idata);
    chk("m_i_ende", i_ende, m_iende);
    chk("m_rsp_valid", rsp_valid, m_rsp_valid);
    if (m_rsp_valid != '0) chk("m_rsp_data", rsp_data, m_rsp_data);
    chk("m_inflight", inflight, m_q.size());
    chk("m_busy", busy, (m_st != S_OFF) || (m_q.size() != 0));
    chk("m_err_orphan", err_orphan, m_orphan);
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", n_errors);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  logic [DW-1:0] pt0, ct0, d0, d1, r1, r5, r6, r7;
  logic [DW-1:0] rv [3];
  int            gseq [4];
  logic [1:0]    rsp_seq [3];

  initial begin
    pt0 = 128'h00112233445566778899AABBCCDDEEFF;
    ct0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    d0  = {16{8'hA0}};
    d1  = {16{8'hB1}};
    r1  = {16{8'hC2}};
    r5  = {16{8'h55}};
    r6  = {16{8'h66}};
    r7  = {16{8'h77}};
    rv[0] = {16{8'hD0}}; rv[1] = {16{8'hD1}}; rv[2] = {16{8'hD2}};
    gseq[0] = 1; gseq[1] = 0; gseq[2] = 1; gseq[3] = 0;
    rsp_seq[0] = 2'b01; rsp_seq[1] = 2'b10; rsp_seq[2] = 2'b01;

    // Reset state
    @(negedge clk);
    chk("rst_i_enable", i_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_req_ready", req_ready, 0);
    step();
    resetL = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("t1_disabled_i_enable", i_enable, 0);

    // 1: single encrypt from requester 0
    step();
    req_valid = 2'b01; req_ende = 2'b00; o_ready = 1'b1;
    req_data[0*DW +: DW] = pt0; req_data[1*DW +: DW] = d1;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 2'b01);
    chk("t1_i_enable", i_enable, 1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_i_data_valid", i_data_valid, 1);
    chk("t1_i_data", i_data, pt0);
    chk("t1_i_ende", i_ende, 0);
    step();
    o_data_valid = 1'b1; o_data = ct0;
    step();
    o_data_valid = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, ct0);
    chk("t1_inflight", inflight, 0);

    // 2: both requesters valid, alternating grants, per-requester mode
    step();
    req_valid = 2'b11; req_ende = 2'b10;
    req_data[0*DW +: DW] = d0; req_data[1*DW +: DW] = d1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_req_ready", req_ready, 2'(1) << gseq[k]);
      step();
      @(negedge clk);
      chk("t2_i_data_valid", i_data_valid, 1);
      chk("t2_i_ende", i_ende, gseq[k]);
      chk("t2_i_data", i_data, (gseq[k] == 1) ? d1 : d0);
      chk("t2_issue_req_ready", req_ready, 0);
      step();
    end

    // 3: tag FIFO full blocks grants, including on the cycle of a pop
    @(negedge clk);
    chk("t3_full_req_ready", req_ready, 0);
    chk("t3_inflight_full", inflight, 4);
    step();
    o_data_valid = 1'b1; o_data = r1;
    @(negedge clk);
    chk("t3_pop_cycle_req_ready", req_ready, 0);
    step();
    o_data_valid = 1'b0;
    @(negedge clk);
    chk("t3_inflight_after_pop", inflight, 3);
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_rsp_data", rsp_data, r1);
    chk("t3_regrant", req_ready, 2'b10);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t3_inflight_refill", inflight, 4);
    step();

    // 4: results routed back in issue order
    o_data_valid = 1'b1; o_data = rv[0];
    for (int k = 0; k < 3; k++) begin
      step();
      if (k < 2) o_data = rv[k+1];
      else o_data_valid = 1'b0;
      @(negedge clk);
      chk("t4_rsp_valid", rsp_valid, rsp_seq[k]);
      chk("t4_rsp_data", rsp_data, rv[k]);
    end
    chk("t4_inflight", inflight, 1);

    // 5: drain with two outstanding, then orphan result
    step();
    req_valid = 2'b01;
    @(negedge clk);
    chk("t5_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b11; en = 1'b0;
    @(negedge clk);
    chk("t5_inflight2", inflight, 2);
    step();
    @(negedge clk);
    chk("t5_drain_req_ready", req_ready, 0);
    chk("t5_drain_i_enable", i_enable, 1);
    step();
    o_data_valid = 1'b1; o_data = r5;
    step();
    o_data_valid = 1'b0;
    @(negedge clk);
    chk("t5_rsp1", rsp_valid, 2'b10);
    chk("t5_i_enable_mid", i_enable, 1);
    step();
    o_data_valid = 1'b1; o_data = r6;
    step();
    o_data_valid = 1'b0;
    @(negedge clk);
    chk("t5_rsp2", rsp_valid, 2'b01);
    chk("t5_rsp2_data", rsp_data, r6);
    chk("t5_inflight0", inflight, 0);
    step();
    @(negedge clk);
    chk("t5_off_i_enable", i_enable, 0);
    chk("t5_off_busy", busy, 0);
    step();
    req_valid = '0; o_data_valid = 1'b1; o_data = r7;
    step();
    o_data_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_orphan", err_orphan, 1);
    chk("t5_orphan_rsp_valid", rsp_valid, 0);
    chk("t5_orphan_inflight", inflight, 0);

    // 6: reset in the middle of an ISSUE cycle
    step();
    en = 1'b1; req_valid = 2'b10;
    step();
    @(negedge clk);
    chk("t6_req_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    #2;
    chk("t6_pre_reset_issue", i_data_valid, 1);
    resetL = 1'b0;
    #1;
    chk("t6_rst_i_data_valid", i_data_valid, 0);
    chk("t6_rst_i_enable", i_enable, 0);
    chk("t6_rst_i_data", i_data, 0);
    chk("t6_rst_inflight", inflight, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err_orphan", err_orphan, 0);
    step();
    step();
    resetL = 1'b1; req_valid = 2'b11;
    req_data[0*DW +: DW] = d0; req_data[1*DW +: DW] = d1;
    @(negedge clk);
    chk("t6_off_req_ready", req_ready, 0);
    step();
    @(negedge clk);
    chk("t6_first_winner", req_ready, 2'b01);
    step();
    @(negedge clk);
    chk("t6_i_data", i_data, d0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
